// File: rtl/switch_debounce_if.sv
// Switch select bus: raw pins in, debounced select value plus change status out.
// Latency: none; this is only a bundle of signals.
// Backpressure: none; every signal is a plain level or a one-cycle strobe.
interface switch_debounce_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] switch_raw;
    logic [WIDTH-1:0] switch;
    logic             switch_valid;
    logic             changed;
    logic [7:0]       change_count;

    // Producer of the raw pins and consumer of the clean bus (board / bench side)
    modport master (
        output switch_raw,
        input  switch,
        input  switch_valid,
        input  changed,
        input  change_count
    );

    // The debouncer itself
    modport slave (
        input  switch_raw,
        output switch,
        output switch_valid,
        output changed,
        output change_count
    );
endinterface

// File: rtl/switch_debounce.sv
// Synchronises and debounces slide switches into a stable register-select bus, with a change strobe and counter.
// Latency: a steady raw level reaches switch DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; the inputs are free-running levels and the outputs are registered levels or strobes.
module switch_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic           clk,
    input  logic           rst_n,
    switch_debounce_if.slave sw
);
    // Counter width covers both the per-bit count (up to DEBOUNCE_CYCLES-1) and the
    // settle count, which saturates at DEBOUNCE_CYCLES+1 so the same width suffices.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] upd;
    logic [CNT_W-1:0] settle_cnt;
    logic             valid_q;
    logic             changed_q;
    logic [7:0]       count_q;

    // A bit is accepted when it has disagreed with the stable value for a full window
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Two-flop synchroniser per bit; only sync2 is used downstream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw.switch_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: count while sync2 disagrees, restart on any agreement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Settle window after reset: valid rises on the (DEBOUNCE_CYCLES+2)-th edge out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end
            if (settle_cnt == SETTLE_LAST) begin
                valid_q <= 1'b1;
            end
        end
    end

    // Change strobe and wrapping counter; updates while still settling are silent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
            count_q   <= '0;
        end else begin
            changed_q <= (|upd) && valid_q;
            if ((|upd) && valid_q) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign sw.switch       = stable;
    assign sw.switch_valid = valid_q;
    assign sw.changed      = changed_q;
    assign sw.change_count = count_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed stimulus with a scoreboard of expected change events.
// Each accepted change pushes {edge, switch, count}; the monitor checks every pulse against it.
// Direct checks cover reset, settle timing, glitch rejection and wrap.
module tb_switch_debounce;
    localparam int W = 3;
    localparam int D = 4;

    typedef struct {
        int unsigned at;
        logic [W-1:0] sw;
        logic [7:0]   cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned edge_no;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned pulse_cnt;
    logic [7:0]  exp_cnt;
    exp_t        q[$];

    switch_debounce_if #(.WIDTH(W)) sw_if ();

    switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the negedge where the final raw value is driven
    task automatic expect_change(input logic [W-1:0] v);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.at  = edge_no + D + 2;
        e.sw  = v;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    // Monitor: every pulse, and every edge where one is due, is compared to the queue head
    always @(negedge clk) begin
        exp_t e;
        bit   hit;
        hit = (q.size() > 0) && (q[0].at == edge_no);
        if (sw_if.changed) pulse_cnt++;
        if (sw_if.changed || hit) begin
            chk("changed_pulse", {31'd0, sw_if.changed}, {31'd0, hit});
            if (hit) begin
                e = q.pop_front();
                chk("pulse_switch", {29'd0, sw_if.switch}, {29'd0, e.sw});
                chk("pulse_count", {24'd0, sw_if.change_count}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        int unsigned p0;
        n_checks = 0;
        n_pass = 0;
        pulse_cnt = 0;
        edge_no = 0;
        exp_cnt = 8'd0;
        rst_n = 1'b0;
        sw_if.switch_raw = 3'b101;

        // 1. Reset and settle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_switch", {29'd0, sw_if.switch}, 32'd0);
            chk("rst_valid", {31'd0, sw_if.switch_valid}, 32'd0);
            chk("rst_changed", {31'd0, sw_if.changed}, 32'd0);
            chk("rst_count", {24'd0, sw_if.change_count}, 32'd0);
        end
        rst_n = 1'b1;
        step(5);
        chk("settle_valid_early", {31'd0, sw_if.switch_valid}, 32'd0);
        chk("settle_switch_early", {29'd0, sw_if.switch}, 32'd0);
        step(1);
        chk("settle_valid", {31'd0, sw_if.switch_valid}, 32'd1);
        chk("settle_switch", {29'd0, sw_if.switch}, 32'b101);
        chk("settle_count", {24'd0, sw_if.change_count}, 32'd0);

        // 2. Clean changes: 101->000 then 000->011
        sw_if.switch_raw = 3'b000;
        expect_change(3'b000);
        step(8);
        sw_if.switch_raw = 3'b011;
        expect_change(3'b011);
        step(5);
        chk("clean_switch_before", {29'd0, sw_if.switch}, 32'b000);
        step(1);
        chk("clean_switch_after", {29'd0, sw_if.switch}, 32'b011);
        chk("clean_changed", {31'd0, sw_if.changed}, 32'd1);
        chk("clean_count", {24'd0, sw_if.change_count}, 32'd2);
        step(2);

        // 3. Glitch: 3-cycle pulse rejected, 4-cycle pulse accepted (and then reverts)
        sw_if.switch_raw = 3'b111;
        step(3);
        sw_if.switch_raw = 3'b011;
        step(10);
        chk("glitch_switch", {29'd0, sw_if.switch}, 32'b011);
        chk("glitch_count", {24'd0, sw_if.change_count}, 32'd2);
        sw_if.switch_raw = 3'b111;
        expect_change(3'b111);
        step(4);
        sw_if.switch_raw = 3'b011;
        expect_change(3'b011);
        step(8);
        chk("pulse4_count", {24'd0, sw_if.change_count}, 32'd4);

        // 4. Bounce on bit 0, then settle at 1
        sw_if.switch_raw = 3'b010;
        expect_change(3'b010);
        step(8);
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            sw_if.switch_raw[0] = ~sw_if.switch_raw[0];
            step(2);
        end
        sw_if.switch_raw = 3'b011;
        expect_change(3'b011);
        step(8);
        chk("bounce_pulses", pulse_cnt - p0, 32'd1);
        chk("bounce_switch", {29'd0, sw_if.switch}, 32'b011);
        chk("bounce_count", {24'd0, sw_if.change_count}, 32'd6);

        // 6. Reset while bit 1's counter sits at 2
        sw_if.switch_raw = 3'b001;
        step(4);
        rst_n = 1'b0;
        exp_cnt = 8'd0;
        step(1);
        chk("midrst_switch", {29'd0, sw_if.switch}, 32'd0);
        chk("midrst_valid", {31'd0, sw_if.switch_valid}, 32'd0);
        chk("midrst_count", {24'd0, sw_if.change_count}, 32'd0);
        chk("midrst_changed", {31'd0, sw_if.changed}, 32'd0);
        step(1);
        sw_if.switch_raw = 3'b110;
        rst_n = 1'b1;
        step(5);
        chk("resettle_valid_early", {31'd0, sw_if.switch_valid}, 32'd0);
        step(1);
        chk("resettle_valid", {31'd0, sw_if.switch_valid}, 32'd1);
        chk("resettle_switch", {29'd0, sw_if.switch}, 32'b110);
        chk("resettle_count", {24'd0, sw_if.change_count}, 32'd0);

        // 5. 256 accepted changes wrap the counter back to 0
        p0 = pulse_cnt;
        for (int i = 0; i < 256; i++) begin
            sw_if.switch_raw = (i % 2 == 0) ? 3'b111 : 3'b110;
            expect_change(sw_if.switch_raw);
            step(7);
        end
        step(2);
        chk("wrap_count", {24'd0, sw_if.change_count}, 32'd0);
        chk("wrap_pulses", pulse_cnt - p0, 32'd256);

        step(10);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
